// File: rtl/sdp_x_mul_pkg.sv
// -----------------------------------------------------------------------------
// sdp_x_mul_pkg
//   Shared constants and types for the SDP X multiplier pipeline.
//   - Default lane geometry (LANES, IN_W, OP_W, OUT_W) used as parameter
//     defaults by sdp_x_mul_pipe and sdp_x_mul_lane.
//   - MAX_SHIFT: the right-shift amount is clamped to this value.
//   - lane_res_t: one rounded/shifted/saturated output lane.
//   - clamp_shift(): applies the MAX_SHIFT clamp to a 6-bit shift request.
// -----------------------------------------------------------------------------
package sdp_x_mul_pkg;

  localparam int LANES_DEF = 16;
  localparam int IN_W_DEF  = 33;
  localparam int OP_W_DEF  = 16;
  localparam int OUT_W_DEF = 32;
  localparam int SHIFT_W   = 6;
  localparam int MAX_SHIFT = 48;

  typedef logic signed [OUT_W_DEF-1:0] lane_res_t;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    return (s > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : s;
  endfunction

endpackage

// File: rtl/sdp_x_mul_lane.sv
// -----------------------------------------------------------------------------
// sdp_x_mul_lane
//   Combinational round / arithmetic-shift / saturate for one lane.
//   res = sat( (prod + (shift>0 ? 1<<(shift-1) : 0)) >>> min(shift, MAX_SHIFT) )
//   saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//
//   Optional build macro: SDP_MUL_SAT_CNT_EN adds the 'sat' output flag.
//
//   Ports:
//     prod   in  PROD_W  signed product from the S1 register
//     shift  in  6       shift amount (unclamped; 0 in bypass)
//     res    out OUT_W   saturated result lane
//     sat    out 1       result was clamped (SDP_MUL_SAT_CNT_EN only)
// -----------------------------------------------------------------------------
module sdp_x_mul_lane
  import sdp_x_mul_pkg::*;
#(
  parameter int PROD_W = IN_W_DEF + OP_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic signed [PROD_W-1:0]  prod,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [OUT_W-1:0]   res
`ifdef SDP_MUL_SAT_CNT_EN
  ,
  output logic                      sat
`endif
);

  // The rounding constant is derived from the unclamped shift (up to 1<<62),
  // so the adder is kept wide enough that it can never wrap.
  localparam int SUM_W = (PROD_W >= 64) ? PROD_W + 1 : 65;

  logic        [SHIFT_W-1:0] sh_amt;
  logic        [SUM_W-1:0]   rnd;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shifted;
  logic                      fits;

  always_comb begin
    sh_amt  = clamp_shift(shift);
    rnd     = (shift != '0) ? (SUM_W'(1) << (shift - SHIFT_W'(1))) : '0;
    sum     = SUM_W'(prod) + $signed(rnd);
    shifted = sum >>> sh_amt;
    // In range when every bit from the output sign bit upward matches.
    fits    = (&shifted[SUM_W-1:OUT_W-1]) || !(|shifted[SUM_W-1:OUT_W-1]);
    if (fits) begin
      res = shifted[OUT_W-1:0];
    end else if (shifted[SUM_W-1]) begin
      res = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

`ifdef SDP_MUL_SAT_CNT_EN
  assign sat = !fits;
`endif

endmodule

// File: rtl/sdp_x_mul_pipe.sv
// -----------------------------------------------------------------------------
// sdp_x_mul_pipe
//   Two-stage per-lane multiplier for the SDP X path.
//     S1: registers lane * cfg_mul_op (full IN_W+OP_W precision), or the
//         sign-extended lane in bypass, together with the beat's shift.
//     S2: registers the rounded / shifted / saturated lanes (sdp_x_mul_lane).
//   Configuration is sampled with the beat on input acceptance, so later cfg
//   changes never touch beats already in the pipe.
//
//   Optional build macro: SDP_MUL_SAT_CNT_EN adds sat_cnt_clr / sat_cnt, a
//   sticking 32-bit count of output transfers in which any lane saturated.
//
//   Ports:
//     nvdla_core_clk   in  1            clock, rising edge
//     nvdla_core_rstn  in  1            asynchronous active-low reset
//     chn_mul_in_vld   in  1            input beat valid
//     chn_mul_in_rdy   out 1            input beat accepted when vld&&rdy
//     chn_mul_in_pd    in  LANES*IN_W   lane i at [i*IN_W +: IN_W]
//     cfg_mul_bypass   in  1            skip multiply (op/shift ignored)
//     cfg_mul_op       in  OP_W         signed multiplier
//     cfg_mul_shift    in  6            right-shift amount
//     chn_mul_out_vld  out 1            output beat valid
//     chn_mul_out_rdy  in  1            downstream accepts
//     chn_mul_out_pd   out LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]
//     sat_cnt_clr      in  1            sync clear of sat_cnt (macro only)
//     sat_cnt          out 32           saturated-beat count (macro only)
// -----------------------------------------------------------------------------
module sdp_x_mul_pipe
  import sdp_x_mul_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     chn_mul_in_vld,
  output logic                     chn_mul_in_rdy,
  input  logic [LANES*IN_W-1:0]    chn_mul_in_pd,
  input  logic                     cfg_mul_bypass,
  input  logic [OP_W-1:0]          cfg_mul_op,
  input  logic [SHIFT_W-1:0]       cfg_mul_shift,
  output logic                     chn_mul_out_vld,
  input  logic                     chn_mul_out_rdy,
  output logic [LANES*OUT_W-1:0]   chn_mul_out_pd
`ifdef SDP_MUL_SAT_CNT_EN
  ,
  input  logic                     sat_cnt_clr,
  output logic [31:0]              sat_cnt
`endif
);

  localparam int PROD_W = IN_W + OP_W;

  // Handshake: a beat moves across an interface on every rising edge where
  // its vld and rdy are both high; vld, once raised, holds with its payload
  // until taken. Each stage loads when it is empty or its successor is
  // draining in the same cycle. in_rdy is built from stage state and out_rdy
  // only, never from in_vld.
  logic s1_vld;
  logic s2_vld;
  logic in_acc;
  logic s2_load;
  logic out_xfer;

  assign chn_mul_in_rdy  = !s1_vld || !s2_vld || chn_mul_out_rdy;
  assign in_acc          = chn_mul_in_vld && chn_mul_in_rdy;
  assign s2_load         = s1_vld && (!s2_vld || chn_mul_out_rdy);
  assign out_xfer        = s2_vld && chn_mul_out_rdy;
  assign chn_mul_out_vld = s2_vld;

  // ---------------------------------------------------------------------------
  // S1: product (or sign-extended lane in bypass)
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0]  prod_next [LANES];
  logic signed [PROD_W-1:0]  s1_prod   [LANES];
  logic        [SHIFT_W-1:0] s1_shift;
  logic        [SHIFT_W-1:0] shift_next;

  for (genvar g = 0; g < LANES; g++) begin : g_prod
    logic signed [IN_W-1:0] lane_in;
    assign lane_in      = $signed(chn_mul_in_pd[g*IN_W +: IN_W]);
    // Both operands widened to PROD_W first, so the product is exact.
    assign prod_next[g] = cfg_mul_bypass ? PROD_W'(lane_in)
                                         : PROD_W'(lane_in) * PROD_W'($signed(cfg_mul_op));
  end

  // Bypass forces shift 0, which also zeroes the rounding constant.
  assign shift_next = cfg_mul_bypass ? '0 : cfg_mul_shift;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld   <= 1'b0;
      s1_shift <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
      end
    end else begin
      if (in_acc) begin
        s1_vld   <= 1'b1;
        s1_prod  <= prod_next;
        s1_shift <= shift_next;
      end else if (s2_load) begin
        s1_vld   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane round / shift / saturate
  // ---------------------------------------------------------------------------
  lane_res_t               lane_res [LANES];
  logic [LANES*OUT_W-1:0]  s2_pd_next;
`ifdef SDP_MUL_SAT_CNT_EN
  logic [LANES-1:0]        lane_sat;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sdp_x_mul_lane #(
      .PROD_W (PROD_W),
      .OUT_W  (OUT_W)
    ) u_lane (
      .prod  (s1_prod[g]),
      .shift (s1_shift),
      .res   (lane_res[g])
`ifdef SDP_MUL_SAT_CNT_EN
      ,
      .sat   (lane_sat[g])
`endif
    );
    assign s2_pd_next[g*OUT_W +: OUT_W] = OUT_W'(lane_res[g]);
  end

  // ---------------------------------------------------------------------------
  // S2: output register; holds while out_vld && !out_rdy
  // ---------------------------------------------------------------------------
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s2_vld         <= 1'b0;
      chn_mul_out_pd <= '0;
    end else begin
      if (s2_load) begin
        s2_vld         <= 1'b1;
        chn_mul_out_pd <= s2_pd_next;
      end else if (out_xfer) begin
        s2_vld         <= 1'b0;
      end
    end
  end

`ifdef SDP_MUL_SAT_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturation counter: counts output transfers carrying any clamped lane,
  // sticks at all-ones, clear wins over increment.
  // ---------------------------------------------------------------------------
  logic s2_sat;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s2_sat  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (s2_load) begin
        s2_sat <= |lane_sat;
      end
      if (sat_cnt_clr) begin
        sat_cnt <= '0;
      end else if (out_xfer && s2_sat && (sat_cnt != 32'hFFFF_FFFF)) begin
        sat_cnt <= sat_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
